// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring shift-subtract on operand magnitudes,
// followed by a sign fix-up cycle. One quotient bit per clock.
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        neg_f = ~v + ONE_VAL;
    endfunction

    // |MIN| = 2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        abs_f = v[WIDTH-1] ? neg_f(v) : v;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic             sign_q_r;
    logic             sign_rm_r;
    logic             zero_r;
    logic             ovf_r;
    logic             load_s;
    logic             step_s;
    logic             fix_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;

    // The shifted partial remainder needs one extra bit so the trial sign is visible.
    assign rem_sh_s = {rem_r, dvd_r[WIDTH-1]};
    assign trial_s  = rem_sh_s - {1'b0, dvs_r};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (B == ZERO_VAL) ? FIX : DIVIDE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIVIDE: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = DIVIDE;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        fix_s  = 1'b0;
        case (state_r)
            IDLE:    load_s = start;
            DIVIDE:  step_s = 1'b1;
            FIX:     fix_s  = 1'b1;
            default: begin
                load_s = 1'b0;
                step_s = 1'b0;
                fix_s  = 1'b0;
            end
        endcase
    end

    // Operand capture, shift-subtract iteration and registered result fix-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            rem_r       <= ZERO_VAL;
            dvd_r       <= ZERO_VAL;
            dvs_r       <= ZERO_VAL;
            sign_q_r    <= 1'b0;
            sign_rm_r   <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= ZERO_VAL;
            remainder   <= ZERO_VAL;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= fix_s;
            if (load_s) begin
                dvd_r       <= abs_f(A);
                dvs_r       <= abs_f(B);
                sign_q_r    <= A[WIDTH-1] ^ B[WIDTH-1];
                sign_rm_r   <= A[WIDTH-1];
                rem_r       <= ZERO_VAL;
                cnt_r       <= {CW{1'b0}};
                zero_r      <= (B == ZERO_VAL);
                ovf_r       <= (A == MIN_VAL) && (B == ONES_VAL);
                busy        <= 1'b1;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end else if (step_s) begin
                if (!trial_s[WIDTH]) begin
                    rem_r <= trial_s[WIDTH-1:0];
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_r <= rem_sh_s[WIDTH-1:0];
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                end
                cnt_r <= cnt_r + CNT_ONE;
            end else if (fix_s) begin
                // On divide-by-zero dvd_r still holds |A|, so remainder restores A.
                if (zero_r) begin
                    quotient  <= ONES_VAL;
                    remainder <= sign_rm_r ? neg_f(dvd_r) : dvd_r;
                end else begin
                    quotient  <= sign_q_r ? neg_f(dvd_r) : dvd_r;
                    remainder <= sign_rm_r ? neg_f(rem_r) : rem_r;
                end
                div_by_zero <= zero_r;
                overflow    <= ovf_r;
                busy        <= 1'b0;
            end else begin
                busy <= busy;
            end
        end
    end

endmodule
